// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// funct3 codes, FSM state encoding and the iteration count.
package alu_muldiv_pkg;

   localparam logic [2:0] FN_MUL    = 3'd0;
   localparam logic [2:0] FN_MULH   = 3'd1;
   localparam logic [2:0] FN_MULHSU = 3'd2;
   localparam logic [2:0] FN_MULHU  = 3'd3;
   localparam logic [2:0] FN_DIV    = 3'd4;
   localparam logic [2:0] FN_DIVU   = 3'd5;
   localparam logic [2:0] FN_REM    = 3'd6;
   localparam logic [2:0] FN_REMU   = 3'd7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PREP = 2'd1;
   localparam logic [1:0] ST_BUSY = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      PREP = ST_PREP,
      BUSY = ST_BUSY,
      DONE = ST_DONE
   } state_t;

   localparam int ITER_COUNT = 32;

endpackage

// File: rtl/alu_muldiv_iter_step.sv
// One radix-2 iteration on the 2*XLEN accumulator: shift-add for multiply,
// restoring shift-subtract for divide. The divide quotient bit leaves on q_bit_o.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   operand_i,
   input  logic              is_div_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic              q_bit_o
);

   logic [XLEN:0]   add_sum;
   logic [XLEN-1:0] sub_diff;

   always_comb begin
      add_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
      // Partial remainder is below the divisor, so the difference fits in XLEN bits
      sub_diff = acc_i[2*XLEN-2:XLEN-1] - operand_i;
      q_bit_o  = 1'b0;
      acc_o    = {add_sum, acc_i[XLEN-1:1]};
      if (is_div_i) begin
         q_bit_o = (acc_i[2*XLEN-1:XLEN-1] >= {1'b0, operand_i});
         acc_o   = {(q_bit_o ? sub_diff : acc_i[2*XLEN-2:XLEN-1]), acc_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response.
// Define ALU_MULDIV_FAST_SPECIAL_EN to retire divide-by-zero and signed overflow straight from IDLE.
module alu_muldiv_iter
   import alu_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            io_req_valid,
   output logic            io_req_ready,
   input  logic [2:0]      io_req_fn,
   input  logic [XLEN-1:0] io_opa,
   input  logic [XLEN-1:0] io_opb,
   input  logic            io_kill,
   output logic            io_resp_valid,
   input  logic            io_resp_ready,
   output logic [XLEN-1:0] io_resp_data
);

   state_t            state_q, state_d;
   logic [2:0]        fn_q, fn_d;
   logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   res_q, res_d;

   logic              is_div, is_rem, a_signed, b_signed, sa, sb, accept;
   logic [XLEN-1:0]   mag_a, mag_b, quo_rem, final_res;
   logic [2*XLEN-1:0] step_acc, acc_next, prod;
   logic              step_q;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .acc_i     (acc_q),
      .operand_i (mcand_q),
      .is_div_i  (is_div),
      .acc_o     (step_acc),
      .q_bit_o   (step_q)
   );

   always_comb begin
      is_div   = fn_q[2];
      is_rem   = fn_q[2] & fn_q[1];
      a_signed = fn_q inside {FN_MULH, FN_MULHSU, FN_DIV, FN_REM};
      b_signed = fn_q inside {FN_MULH, FN_DIV, FN_REM};
      sa       = a_signed & opa_q[XLEN-1];
      sb       = b_signed & opb_q[XLEN-1];
      mag_a    = sa ? -opa_q : opa_q;
      mag_b    = sb ? -opb_q : opb_q;
      acc_next = is_div ? {step_acc[2*XLEN-1:1], step_q} : step_acc;
      prod     = neg_q ? -acc_next : acc_next;
      quo_rem  = is_rem ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
      if (is_div) begin
         final_res = neg_q ? -quo_rem : quo_rem;
      end else begin
         final_res = (fn_q == FN_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   end

`ifdef ALU_MULDIV_FAST_SPECIAL_EN
   logic            sp_div0, sp_ovf;
   logic [XLEN-1:0] sp_res;

   always_comb begin
      sp_div0 = io_req_fn[2] & (io_opb == '0);
      sp_ovf  = io_req_fn[2] & ~io_req_fn[0] & (io_opa == {1'b1, {(XLEN-1){1'b0}}}) & (&io_opb);
      sp_res  = sp_div0 ? (io_req_fn[1] ? io_opa : '1) : (io_req_fn[1] ? '0 : io_opa);
   end
`endif

   always_comb begin
      accept  = io_req_valid & (state_q == IDLE) & ~io_kill;
      state_d = state_q;
      fn_d    = fn_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               fn_d    = io_req_fn;
               opa_d   = io_opa;
               opb_d   = io_opb;
               state_d = PREP;
`ifdef ALU_MULDIV_FAST_SPECIAL_EN
               if (sp_div0 | sp_ovf) begin
                  state_d = DONE;
                  res_d   = sp_res;
               end
`endif
            end
         end
         PREP: begin
            // A zero divisor must leave the quotient as all ones, so it never flips sign
            if (!is_div)     neg_d = sa ^ sb;
            else if (is_rem) neg_d = sa;
            else             neg_d = (sa ^ sb) & (opb_q != '0);
            acc_d   = {{XLEN{1'b0}}, mag_a};
            mcand_d = mag_b;
            cnt_d   = '0;
            state_d = BUSY;
         end
         BUSY: begin
            acc_d = acc_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(ITER_COUNT - 1)) begin
               state_d = DONE;
               res_d   = final_res;
            end
         end
         DONE: begin
            if (io_resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (io_kill) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         fn_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         fn_q    <= fn_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
      end
   end

   assign io_req_ready  = (state_q == IDLE);
   assign io_resp_valid = (state_q == DONE);
   assign io_resp_data  = res_q;

endmodule
